// File: rtl/nios2_oci_mem_pkg.sv
// Shared types for the OCI monitor-RAM arbiter: FSM states, grant owner
// and the pending JTAG operation.
package nios2_oci_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDWAIT,
    RESP
  } state_t;

  typedef enum logic {
    GNT_CPU,
    GNT_JTAG
  } grant_t;

  typedef enum logic [1:0] {
    NONE,
    RD,
    WR
  } jop_t;

endpackage

// File: rtl/nios2_oci_rr_arb2.sv
// Two-way round-robin arbiter between the CPU slave port and the JTAG
// pending command. Grants only while eval is high (FSM in IDLE); a tie goes
// to the requester that was not granted last. last_grant resets to JTAG so
// the CPU wins the first tie.
module nios2_oci_rr_arb2
  import nios2_oci_mem_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   eval,
  input  logic   req_cpu,
  input  logic   req_jtag,
  output logic   gnt_valid,
  output grant_t gnt
);

  grant_t last_grant;

  // Grant selection: single requester wins outright, ties alternate.
  // NOTE: every output of this block gets a value on every path (defaults first), so no latch is inferred.
  always_comb begin
    gnt_valid = eval & (req_cpu | req_jtag);
    gnt       = GNT_JTAG;
    if (req_cpu && req_jtag) begin
      gnt = (last_grant == GNT_CPU) ? GNT_JTAG : GNT_CPU;
    end else if (req_cpu) begin
      gnt = GNT_CPU;
    end
  end

  // Remember the most recent winner for the next tie.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= GNT_JTAG;
    end else if (gnt_valid) begin
      last_grant <= gnt;
    end
  end

endmodule

// File: rtl/nios2_oci_mem_arbiter.sv
// Shares the single port of the OCI debug monitor RAM between the JTAG
// debug host (sysclk-domain action pulses) and the CPU debug slave port.
// Optional CPU write protection of the upper RAM region is compiled in with
// the macro NIOS2_OCI_MEM_PROTECT_EN.
module nios2_oci_mem_arbiter
  import nios2_oci_mem_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] PROT_BASE = 8'hC0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                jtag_load_addr,
  input  logic [ADDR_W-1:0]   jtag_addr,
  input  logic                jtag_rd,
  input  logic                jtag_wr,
  input  logic [DATA_W-1:0]   jtag_wdata,
  output logic [DATA_W-1:0]   mon_dreg,
  output logic                jtag_busy,
  output logic                jtag_overrun,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_byteen,
  output logic                cpu_waitrequest,
  output logic [DATA_W-1:0]   cpu_readdata,
  output logic                cpu_readdatavalid,
  output logic                cpu_error,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W/8-1:0] ram_be,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  state_t              state, state_nxt;
  jop_t                jtag_pend;
  logic                jtag_in_svc;
  logic [ADDR_W-1:0]   jtag_ptr;
  logic [DATA_W-1:0]   jtag_wdata_q;
  grant_t              svc;
  logic                svc_rd;
  logic                gnt_valid;
  grant_t              gnt;
  logic                accept_cpu, accept_jtag;
  logic                jtag_pulse;
  logic                prot_hit;
  logic [ADDR_W-1:0]   jtag_addr_eff;

  nios2_oci_rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .eval      (state == IDLE),
    .req_cpu   (cpu_read | cpu_write),
    .req_jtag  (jtag_pend != NONE),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  assign accept_cpu  = gnt_valid && (gnt == GNT_CPU);
  assign accept_jtag = gnt_valid && (gnt == GNT_JTAG);
  assign jtag_pulse  = jtag_rd | jtag_wr;
  assign jtag_busy   = (jtag_pend != NONE) | jtag_in_svc;
  // A load in the grant cycle itself redirects the access to the new address.
  assign jtag_addr_eff   = jtag_load_addr ? jtag_addr : jtag_ptr;
  assign cpu_waitrequest = reset | ~accept_cpu;

`ifdef NIOS2_OCI_MEM_PROTECT_EN
  assign prot_hit = cpu_write && (cpu_addr >= PROT_BASE);

  // Error strobe in the cycle after a protected CPU write is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cpu_error <= 1'b0;
    else       cpu_error <= accept_cpu & prot_hit;
  end
`else
  logic unused_prot_base;
  assign prot_hit         = 1'b0;
  assign cpu_error        = 1'b0;
  assign unused_prot_base = ^PROT_BASE;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: writes finish after ACCESS, reads walk RDWAIT and RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = svc_rd ? RDWAIT : IDLE;
      RDWAIT:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM port registers, loaded from the winning request in the grant cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_be    <= '0;
      ram_wdata <= '0;
      svc       <= GNT_CPU;
      svc_rd    <= 1'b0;
    end else begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      if (accept_cpu) begin
        svc       <= GNT_CPU;
        svc_rd    <= ~cpu_write;
        ram_en    <= ~prot_hit;
        ram_we    <= cpu_write & ~prot_hit;
        ram_addr  <= cpu_addr;
        ram_be    <= cpu_byteen;
        ram_wdata <= cpu_wdata;
      end else if (accept_jtag) begin
        svc       <= GNT_JTAG;
        svc_rd    <= (jtag_pend == RD);
        ram_en    <= 1'b1;
        ram_we    <= (jtag_pend == WR);
        ram_addr  <= jtag_addr_eff;
        ram_be    <= '1;
        ram_wdata <= jtag_wdata_q;
      end
    end
  end

  // Read return: capture in RDWAIT, present to the owner in RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_readdata      <= '0;
      cpu_readdatavalid <= 1'b0;
      mon_dreg          <= '0;
    end else begin
      cpu_readdatavalid <= 1'b0;
      if (state == RDWAIT) begin
        if (svc == GNT_CPU) begin
          cpu_readdata      <= ram_rdata;
          cpu_readdatavalid <= 1'b1;
        end else begin
          mon_dreg <= ram_rdata;
        end
      end
    end
  end

  // JTAG command latch, address pointer and overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jtag_pend    <= NONE;
      jtag_in_svc  <= 1'b0;
      jtag_ptr     <= '0;
      jtag_wdata_q <= '0;
      jtag_overrun <= 1'b0;
    end else begin
      if (accept_jtag) begin
        jtag_pend   <= NONE;
        jtag_in_svc <= 1'b1;
        jtag_ptr    <= jtag_addr_eff + ADDR_W'(1);
      end else if (jtag_load_addr && !jtag_in_svc) begin
        jtag_ptr <= jtag_addr;
      end
      // Service ends when the write has been issued or the read data captured.
      if (jtag_in_svc && ((state == ACCESS && !svc_rd) || state == RDWAIT)) begin
        jtag_in_svc <= 1'b0;
      end
      if (jtag_pulse && !jtag_busy) begin
        jtag_pend    <= jtag_wr ? WR : RD;
        jtag_wdata_q <= jtag_wdata;
      end
      // A dropped pulse in the same cycle as a load keeps the flag set.
      if (jtag_pulse && jtag_busy) jtag_overrun <= 1'b1;
      else if (jtag_load_addr)     jtag_overrun <= 1'b0;
    end
  end

endmodule
